digit_feature: RTL

// Consumes digit bounding boxes from projection's border RAMs once project_done_flag rises.

---
 rtl/digit_pkg.sv | 21 ++
 rtl/digit_scan_unit.sv | 108 ++++++++++
 rtl/digit_feature.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/digit_pkg.sv
// Shared types and constants for the digit feature extractor.
package digit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DERIVE,
        ST_WAIT,
        ST_SCAN,
        ST_OUT
    } state_t;

    localparam int unsigned MUL_1_3 = 85;
    localparam int unsigned MUL_2_3 = 170;
    localparam int unsigned CNT_W   = 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/digit_scan_unit.sv
// One digit box: holds its borders and derived scan lines, and counts
// background->foreground crossings on the vertical and two horizontal lines.
module digit_scan_unit
    import digit_pkg::*;
#(
    parameter int DEPBIT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_l,
    input  logic              ld_r,
    input  logic              ld_t,
    input  logic              ld_b,
    input  logic [DEPBIT-1:0] col_data,
    input  logic [DEPBIT-1:0] row_data,
    input  logic              derive,
    input  logic              clr,
    input  logic              pix_en,
    input  logic              fg,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic [CNT_W-1:0]  cnt_v,
    output logic [CNT_W-1:0]  cnt_h1,
    output logic [CNT_W-1:0]  cnt_h2
);

    logic [DEPBIT-1:0] x_l, x_r, y_t, y_b, x_m, y_1, y_2;
    logic              prev_v, prev_h1, prev_h2;

    logic [DEPBIT-1:0] l_eff;
    logic [DEPBIT:0]   x_sum;
    logic [17:0]       d, p1, p2;
    logic [DEPBIT-1:0] y1_n, y2_n;

    always_comb begin
        l_eff = (x_l > x_r) ? '0 : x_l;
        x_sum = {1'b0, l_eff} + {1'b0, x_r};
        d     = (y_b >= y_t) ? 18'(y_b - y_t) : '0;
        p1    = d * 18'(MUL_1_3);
        p2    = d * 18'(MUL_2_3);
        y1_n  = DEPBIT'(18'(y_t) + (p1 >> 8));
        y2_n  = DEPBIT'(18'(y_t) + (p2 >> 8));
    end

    logic on_v, on_h1, on_h2;
    logic pv, ph1, ph2;

    // The previous-pixel bit is forced clear at the start of each line segment.
    always_comb begin
        on_v  = pix_en && (xpos == 11'(x_m)) && (ypos >= 11'(y_t)) && (ypos <= 11'(y_b));
        on_h1 = pix_en && (ypos == 11'(y_1)) && (xpos >= 11'(x_l)) && (xpos <= 11'(x_r));
        on_h2 = pix_en && (ypos == 11'(y_2)) && (xpos >= 11'(x_l)) && (xpos <= 11'(x_r));
        pv    = (ypos == 11'(y_t)) ? 1'b0 : prev_v;
        ph1   = (xpos == 11'(x_l)) ? 1'b0 : prev_h1;
        ph2   = (xpos == 11'(x_l)) ? 1'b0 : prev_h2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_l     <= '0;
            x_r     <= '0;
            y_t     <= '0;
            y_b     <= '0;
            x_m     <= '0;
            y_1     <= '0;
            y_2     <= '0;
            prev_v  <= 1'b0;
            prev_h1 <= 1'b0;
            prev_h2 <= 1'b0;
            cnt_v   <= '0;
            cnt_h1  <= '0;
            cnt_h2  <= '0;
        end else begin
            if (ld_l) x_l <= col_data;
            if (ld_r) x_r <= col_data;
            if (ld_t) y_t <= row_data;
            if (ld_b) y_b <= row_data;
            if (derive) begin
                x_l <= l_eff;
                x_m <= x_sum[DEPBIT:1];
                y_1 <= y1_n;
                y_2 <= y2_n;
            end
            if (clr) begin
                prev_v  <= 1'b0;
                prev_h1 <= 1'b0;
                prev_h2 <= 1'b0;
                cnt_v   <= '0;
                cnt_h1  <= '0;
                cnt_h2  <= '0;
            end else begin
                if (on_v) begin
                    prev_v <= fg;
                    if (fg && !pv) cnt_v <= sat_inc(cnt_v);
                end
                if (on_h1) begin
                    prev_h1 <= fg;
                    if (fg && !ph1) cnt_h1 <= sat_inc(cnt_h1);
                end
                if (on_h2) begin
                    prev_h2 <= fg;
                    if (fg && !ph2) cnt_h2 <= sat_inc(cnt_h2);
                end
            end
        end
    end

endmodule

// File: rtl/digit_feature.sv
// Loads digit boxes from the projection border RAMs, scans one frame with three
// lines per box and emits a crossing-count feature triple per digit.
module digit_feature
    import digit_pkg::*;
#(
    parameter int NUM_ROW = 1,
    parameter int NUM_COL = 4,
    parameter int H_PIXEL = 480,
    parameter int V_PIXEL = 272,
    parameter int DEPBIT  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              project_done_flag,
    input  logic [3:0]        num_col,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    input  logic              frame_vsync,
    input  logic              frame_de,
    input  logic              monoc,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic              busy,
    output logic              feat_valid,
    output logic [3:0]        feat_idx,
    output logic [1:0]        feat_v,
    output logic [1:0]        feat_h1,
    output logic [1:0]        feat_h2,
    output logic              feat_done
);

    localparam int IDX_W    = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int ROW_LAST = (NUM_ROW > 0) ? 2 : 0;

    state_t     state, state_nx;
    logic       pdf_d, vs_d;
    logic [3:0] ncol, ncol_in, out_cnt;
    logic [4:0] load_cnt;
    logic       trig, vs_fall, load_last, pix_en;

    logic [CNT_W-1:0] cnt_v_a [NUM_COL];
    logic [CNT_W-1:0] cnt_h1_a[NUM_COL];
    logic [CNT_W-1:0] cnt_h2_a[NUM_COL];

    always_comb begin
        ncol_in   = (num_col > 4'(NUM_COL)) ? 4'(NUM_COL) : num_col;
        trig      = project_done_flag && !pdf_d;
        vs_fall   = vs_d && !frame_vsync;
        load_last = (load_cnt == {ncol, 1'b0});
        pix_en    = (state == ST_SCAN) && frame_de && !vs_fall &&
                    (xpos < 11'(H_PIXEL)) && (ypos < 11'(V_PIXEL));
        busy      = (state != ST_IDLE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (trig) state_nx = (ncol_in == '0) ? ST_OUT : ST_LOAD;
            ST_LOAD:   if (load_last) state_nx = ST_DERIVE;
            ST_DERIVE: state_nx = ST_WAIT;
            ST_WAIT:   if (vs_fall) state_nx = ST_SCAN;
            ST_SCAN:   if (vs_fall) state_nx = ST_OUT;
            ST_OUT:    if (out_cnt == ncol) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Addresses lead the captured data by one cycle; load_cnt tracks the data side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdf_d              <= 1'b0;
            vs_d               <= 1'b0;
            ncol               <= '0;
            load_cnt           <= '0;
            out_cnt            <= '0;
            col_border_addr_rd <= '0;
            row_border_addr_rd <= '0;
        end else begin
            pdf_d <= project_done_flag;
            vs_d  <= frame_vsync;
            case (state)
                ST_IDLE: if (trig) begin
                    ncol               <= ncol_in;
                    load_cnt           <= '0;
                    out_cnt            <= '0;
                    col_border_addr_rd <= (ncol_in != '0) ? DEPBIT'(1) : '0;
                    row_border_addr_rd <= (ncol_in != '0) ? DEPBIT'(1) : '0;
                end
                ST_LOAD: begin
                    load_cnt <= load_cnt + 5'd1;
                    col_border_addr_rd <= (col_border_addr_rd < DEPBIT'({ncol, 1'b0}))
                                          ? col_border_addr_rd + 1'b1 : '0;
                    row_border_addr_rd <= (row_border_addr_rd < DEPBIT'(ROW_LAST))
                                          ? row_border_addr_rd + 1'b1 : '0;
                end
                ST_SCAN: if (vs_fall) out_cnt <= '0;
                ST_OUT:  out_cnt <= out_cnt + 4'd1;
                default: ;
            endcase
        end
    end

    logic emit;
    assign emit = (state == ST_OUT) && (out_cnt < ncol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_valid <= 1'b0;
            feat_done  <= 1'b0;
            feat_idx   <= '0;
            feat_v     <= '0;
            feat_h1    <= '0;
            feat_h2    <= '0;
        end else begin
            feat_valid <= emit;
            feat_done  <= (state == ST_OUT) && (out_cnt == ncol);
            feat_idx   <= emit ? out_cnt : '0;
            feat_v     <= emit ? cnt_v_a [out_cnt[IDX_W-1:0]] : '0;
            feat_h1    <= emit ? cnt_h1_a[out_cnt[IDX_W-1:0]] : '0;
            feat_h2    <= emit ? cnt_h2_a[out_cnt[IDX_W-1:0]] : '0;
        end
    end

    for (genvar k = 0; k < NUM_COL; k++) begin : g_unit
        digit_scan_unit #(.DEPBIT(DEPBIT)) u_scan (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld_l     ((state == ST_LOAD) && (load_cnt == 5'(2 * k + 1))),
            .ld_r     ((state == ST_LOAD) && (load_cnt == 5'(2 * k + 2))),
            .ld_t     ((state == ST_LOAD) && (load_cnt == 5'd1)),
            .ld_b     ((state == ST_LOAD) && (load_cnt == 5'd2)),
            .col_data (col_border_data_rd),
            .row_data (row_border_data_rd),
            .derive   (state == ST_DERIVE),
            .clr      ((state == ST_WAIT) && vs_fall),
            .pix_en   (pix_en),
            .fg       (!monoc),
            .xpos     (xpos),
            .ypos     (ypos),
            .cnt_v    (cnt_v_a[k]),
            .cnt_h1   (cnt_h1_a[k]),
            .cnt_h2   (cnt_h2_a[k])
        );
    end

endmodule
